// File: rtl/mixcol_addkey_serial.sv
// Column-serial AES MixColumns + AddRoundKey: one column per clock, result held until accepted.
// Optional macro MIXCOL_LASTROUND_EN adds a last_round input that bypasses MixColumns.
module mixcol_addkey_serial (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic [127:0] key_in,
`ifdef MIXCOL_LASTROUND_EN
   input  logic         last_round,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t         fsm_reg;
   logic [127:0] data_reg;
   logic [127:0] key_reg;
   logic [1:0]   col_reg;
   logic         in_ready_reg;
   logic         out_valid_reg;
   logic         busy_reg;
   logic         bypass;

   logic [6:0]   col_base;
   logic [31:0]  col_data;
   logic [31:0]  col_key;
   logic [31:0]  col_mixed;
   logic [31:0]  col_next;
   logic [7:0]   col_byte [4];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef MIXCOL_LASTROUND_EN
   logic last_round_reg;
   assign bypass = last_round_reg;
`else
   assign bypass = 1'b0;
`endif

   assign col_base = {col_reg, 5'b00000};
   assign col_data = data_reg[col_base +: 32];
   assign col_key  = key_reg[col_base +: 32];

   // Row r output: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], indices mod 4.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         assign col_byte[gi] = col_data[8*gi +: 8];
         assign col_mixed[8*gi +: 8] = xtime(col_byte[gi])
                                     ^ xtime(col_byte[(gi+1)%4]) ^ col_byte[(gi+1)%4]
                                     ^ col_byte[(gi+2)%4]
                                     ^ col_byte[(gi+3)%4];
      end
   endgenerate

   assign col_next  = (bypass ? col_data : col_mixed) ^ col_key;

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign state_out = data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg        <= IDLE;
         data_reg       <= '0;
         key_reg        <= '0;
         col_reg        <= 2'd0;
         in_ready_reg   <= 1'b1;
         out_valid_reg  <= 1'b0;
         busy_reg       <= 1'b0;
`ifdef MIXCOL_LASTROUND_EN
         last_round_reg <= 1'b0;
`endif
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg       <= state_in;
                  key_reg        <= key_in;
                  col_reg        <= 2'd0;
                  fsm_reg        <= RUN;
                  in_ready_reg   <= 1'b0;
                  busy_reg       <= 1'b1;
`ifdef MIXCOL_LASTROUND_EN
                  last_round_reg <= last_round;
`endif
               end
            end
            RUN: begin
               data_reg[col_base +: 32] <= col_next;
               col_reg <= col_reg + 2'd1;
               if (col_reg == 2'd3) begin
                  fsm_reg       <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm_reg       <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               fsm_reg       <= IDLE;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mixcol_addkey_serial.sv
// Randomized bench for mixcol_addkey_serial against a GF(2^8) matrix-product reference model.
// Compile with MIXCOL_LASTROUND_EN to also exercise the last-round bypass.
module tb_mixcol_addkey_serial;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;
`ifdef MIXCOL_LASTROUND_EN
   logic         last_round;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mixcol_addkey_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .key_in    (key_in),
`ifdef MIXCOL_LASTROUND_EN
      .last_round(last_round),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
      n_tests++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Generic shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                          input logic lr);
      logic [7:0]   coef [4];
      logic [127:0] r = '0;
      logic [7:0]   acc;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            if (lr) begin
               acc = s[32*c + 8*row +: 8];
            end else begin
               acc = 8'h00;
               for (int j = 0; j < 4; j++)
                  acc = acc ^ gmul(coef[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
            end
            r[32*c + 8*row +: 8] = acc ^ k[32*c + 8*row +: 8];
         end
      end
      return r;
   endfunction

   // One full transaction: accept, latency, result, optional back-pressure, output handshake.
   task automatic do_txn(input logic [127:0] s, input logic [127:0] k, input logic lr,
                         input logic [127:0] req, input int hold, input bit noise);
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         step();
         cnt++;
      end
      check("in_ready_idle", {127'd0, in_ready}, 128'd1);
      state_in = s;
      key_in   = k;
`ifdef MIXCOL_LASTROUND_EN
      last_round = lr;
`endif
      in_valid  = 1'b1;
      out_ready = noise ? 1'($urandom % 2) : 1'b0;
      step();
      check("busy_run", {127'd0, busy}, 128'd1);
      check("in_ready_run", {127'd0, in_ready}, 128'd0);
      cnt = 0;
      in_valid = 1'b0;
      while (!out_valid && cnt < 20) begin
         if (noise) begin
            in_valid  = 1'($urandom % 2);
            state_in  = {$urandom, $urandom, $urandom, $urandom};
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom % 2);
         end
         step();
         cnt++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", 128'(cnt), 128'd4);
      check("result", state_out, req);
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_valid", {127'd0, out_valid}, 128'd1);
         check("hold_data", state_out, req);
         check("hold_in_ready", {127'd0, in_ready}, 128'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_valid", {127'd0, out_valid}, 128'd0);
      check("post_in_ready", {127'd0, in_ready}, 128'd1);
      check("post_busy", {127'd0, busy}, 128'd0);
      $display("[TB] txn s=%h k=%h lr=%0d hold=%0d -> %h", s, k, lr, hold, req);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] s, k, e;
      logic         lr;
      logic [127:0] exp_q[$];
      int           cyc, last_acc, nacc, nres;
      bit           acc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      state_in  = '0;
      key_in    = '0;
`ifdef MIXCOL_LASTROUND_EN
      last_round = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #3;
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_state_out", state_out, 128'd0);
      rst_n = 1'b1;
      step();
      check("rst_in_ready", {127'd0, in_ready}, 128'd1);

      do_txn({4{32'h455313db}}, 128'd0, 1'b0, {4{32'hbca14d8e}}, 0, 1'b0);
      do_txn({4{32'hc6c6c6c6}}, {128{1'b1}}, 1'b0, {4{32'h39393939}}, 10, 1'b0);
`ifdef MIXCOL_LASTROUND_EN
      do_txn({4{32'h455313db}}, {4{32'h01010101}}, 1'b1, {4{32'h445212da}}, 0, 1'b0);
`endif

      for (int t = 0; t < 20; t++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_LASTROUND_EN
         lr = 1'($urandom % 2);
`else
         lr = 1'b0;
`endif
         do_txn(s, k, lr, model(s, k, lr), int'($urandom_range(0, 3)), 1'b1);
      end

      // Reset after column 1 has been written: in-flight data is dropped.
      state_in = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
      check("midrst_busy", {127'd0, busy}, 128'd0);
      check("midrst_state", state_out, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("midrst_no_output", {127'd0, out_valid}, 128'd0);
         check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
      end
      $display("[TB] mid-run reset applied and released");
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      do_txn(s, k, 1'b0, model(s, k, 1'b0), 1, 1'b0);

      // Back-to-back streaming with in_valid held high and out_ready=1.
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      state_in  = s;
      key_in    = k;
`ifdef MIXCOL_LASTROUND_EN
      last_round = 1'b0;
`endif
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc = 0; last_acc = 0; nacc = 0; nres = 0;
      while (nres < 5 && cyc < 200) begin
         acc = in_ready && in_valid;
         step();
         cyc++;
         if (acc) begin
            exp_q.push_back(model(s, k, 1'b0));
            if (nacc > 0) check("b2b_interval", 128'(cyc - last_acc), 128'd6);
            last_acc = cyc;
            nacc++;
            if (nacc == 5) begin
               in_valid = 1'b0;
            end else begin
               s = {$urandom, $urandom, $urandom, $urandom};
               k = {$urandom, $urandom, $urandom, $urandom};
               state_in = s;
               key_in   = k;
            end
         end
         if (out_valid) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("b2b_result", state_out, e);
               $display("[TB] b2b result %0d at cycle %0d: %h", nres, cyc, state_out);
            end else begin
               check("b2b_spurious_output", {127'd0, out_valid}, 128'd0);
            end
            nres++;
         end
      end
      out_ready = 1'b0;
      check("b2b_count", 128'(nres), 128'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
